// File: rtl/xor_decrypt_stream_if.sv
// Byte-stream handshake bundle for xor_decrypt_stream.
// master drives control and bytes in; slave is the decryptor.
interface xor_decrypt_stream_if #(
  parameter int KEY_SIZE = 32
);
  logic                iStart;
  logic [KEY_SIZE-1:0] iKey;
  logic [7:0]          iCipher_byte;
  logic                iCipher_valid;
  logic                oCipher_ready;
  logic [7:0]          oPlain_byte;
  logic                oPlain_valid;
  logic                iPlain_ready;
  logic                oBusy;
  logic                oDecrypt_done;

  modport master (
    output iStart, iKey, iCipher_byte,
    output iCipher_valid, iPlain_ready,
    input  oCipher_ready, oPlain_byte,
    input  oPlain_valid, oBusy, oDecrypt_done
  );

  modport slave (
    input  iStart, iKey, iCipher_byte,
    input  iCipher_valid, iPlain_ready,
    output oCipher_ready, oPlain_byte,
    output oPlain_valid, oBusy, oDecrypt_done
  );
endinterface

// File: rtl/xor_decrypt_stream.sv
// Byte-serial XOR decryptor: load N cipher bytes, drain N plain bytes.
// Optional XOR_DECRYPT_CKSUM_EN adds oChecksum (running XOR of plaintext).
module xor_decrypt_stream #(
  parameter int KEY_SIZE = 32,
  parameter int MSG_SIZE = 512
) (
  input  logic iClk,
  input  logic iRst,
  xor_decrypt_stream_if.slave bus
`ifdef XOR_DECRYPT_CKSUM_EN
  ,
  output logic [7:0] oChecksum
`endif
);

  localparam int N  = MSG_SIZE / 8;
  localparam int K  = KEY_SIZE / 8;
  localparam int CW = $clog2(N) + 1;
  localparam int AW = $clog2(N);
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [KEY_SIZE-1:0] r_key;
  logic [7:0]          r_buf [N];
  logic [CW-1:0]       r_in_cnt;
  logic [CW-1:0]       r_out_cnt;
  logic [KW-1:0]       r_kidx;

  logic       w_start;
  logic       w_in_fire;
  logic       w_out_fire;
  logic [7:0] w_key_byte;
  logic [7:0] w_plain;

`ifdef XOR_DECRYPT_CKSUM_EN
  logic [7:0] r_cksum;
  assign oChecksum = r_cksum;
`endif

  assign w_key_byte = r_key[KEY_SIZE-1-8*r_kidx -: 8];
  assign w_plain    = bus.iCipher_byte ^ w_key_byte;

  // State register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and handshake decode
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_in_fire  = 1'b0;
    w_out_fire = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.iStart) begin
          w_start = 1'b1;
          w_next  = S_LOAD;
        end
      end
      S_LOAD: begin
        w_in_fire = bus.iCipher_valid;
        if (w_in_fire && r_in_cnt == CW'(N - 1))
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_out_fire = bus.iPlain_ready;
        if (w_out_fire && r_out_cnt == CW'(N - 1))
          w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Key latch, buffer write, counters
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_key     <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_kidx    <= '0;
      for (int i = 0; i < N; i++) r_buf[i] <= 8'h00;
`ifdef XOR_DECRYPT_CKSUM_EN
      r_cksum   <= 8'h00;
`endif
    end else begin
      if (w_start) begin
        r_key     <= bus.iKey;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
        r_kidx    <= '0;
`ifdef XOR_DECRYPT_CKSUM_EN
        r_cksum   <= 8'h00;
`endif
      end
      if (w_in_fire) begin
        r_buf[r_in_cnt[AW-1:0]] <= w_plain;
        r_in_cnt <= r_in_cnt + 1'b1;
        if (r_kidx == KW'(K - 1)) r_kidx <= '0;
        else                      r_kidx <= r_kidx + 1'b1;
`ifdef XOR_DECRYPT_CKSUM_EN
        r_cksum <= r_cksum ^ w_plain;
`endif
      end
      if (w_out_fire)
        r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    bus.oCipher_ready = (r_state == S_LOAD);
    bus.oPlain_valid  = (r_state == S_DRAIN);
    bus.oBusy         = (r_state == S_LOAD) ||
                        (r_state == S_DRAIN);
    bus.oDecrypt_done = (r_state == S_DONE);
    bus.oPlain_byte   = 8'h00;
    if (r_state == S_DRAIN)
      bus.oPlain_byte = r_buf[r_out_cnt[AW-1:0]];
  end

endmodule

// File: tb/tb_xor_decrypt_stream.sv
// Directed bench for xor_decrypt_stream with a plaintext scoreboard.
// Expected bytes are queued at ciphertext send, checked at drain.
module tb_xor_decrypt_stream;

  localparam int KS = 32;
  localparam int MS = 512;
  localparam int N  = MS / 8;

  logic iClk;
  logic iRst;
  int   n_cmp;
  int   n_bad;

  logic [7:0]    q[$];
  logic [KS-1:0] ekey;
  logic [MS-1:0] blk;
  logic [MS-1:0] msg;

  xor_decrypt_stream_if #(.KEY_SIZE(KS)) bus ();

`ifdef XOR_DECRYPT_CKSUM_EN
  logic [7:0] cksum;
`endif

  xor_decrypt_stream #(
    .KEY_SIZE(KS),
    .MSG_SIZE(MS)
  ) dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus (bus)
`ifdef XOR_DECRYPT_CKSUM_EN
    ,
    .oChecksum(cksum)
`endif
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic start(input logic [KS-1:0] k);
    ekey = k;
    bus.iKey = k;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    check("start_ready", bus.oCipher_ready, 1);
    check("start_done", bus.oDecrypt_done, 0);
    check("start_busy", bus.oBusy, 1);
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    logic fired;
    t = 0;
    fired = 1'b0;
    bus.iCipher_byte = b;
    bus.iCipher_valid = 1'b1;
    while (!fired && t < 50) begin
      fired = bus.oCipher_ready;
      tick();
      t++;
    end
    bus.iCipher_valid = 1'b0;
    if (!fired) check("send_timeout", fired, 1);
  endtask

  task automatic feed(input int lo, input int hi,
                      input int gap);
    logic [7:0] cb;
    logic [7:0] kb;
    for (int i = lo; i <= hi; i++) begin
      if (gap > 0) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(99) < gap) begin
            bus.iCipher_valid = 1'b0;
            bus.iCipher_byte = 8'($urandom);
            tick();
          end
        end
      end
      cb = blk[MS-1-8*i -: 8];
      kb = ekey[KS-1-8*(i%4) -: 8];
      q.push_back(cb ^ kb);
      send(cb);
    end
  endtask

  task automatic drain(input int n, input int stall);
    int t;
    int got;
    logic r;
    t = 0;
    got = 0;
    while (got < n && t < 2000) begin
      r = ($urandom_range(99) >= stall);
      bus.iPlain_ready = r;
      check("plain_valid", bus.oPlain_valid, 1);
      if (q.size() > 0)
        check("plain_byte", bus.oPlain_byte, q[0]);
      tick();
      if (r) begin
        void'(q.pop_front());
        got++;
      end
      t++;
    end
    bus.iPlain_ready = 1'b0;
    check("drain_count", got, n);
  endtask

  task automatic check_done();
    check("done_flag", bus.oDecrypt_done, 1);
    check("done_valid", bus.oPlain_valid, 0);
    check("done_busy", bus.oBusy, 0);
    check("done_ready", bus.oCipher_ready, 0);
    check("sb_empty", q.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, bus.oCipher_ready, 0);
    check({tag, "_valid"}, bus.oPlain_valid, 0);
    check({tag, "_byte"}, bus.oPlain_byte, 0);
    check({tag, "_busy"}, bus.oBusy, 0);
    check({tag, "_done"}, bus.oDecrypt_done, 0);
  endtask

  task automatic count_blk();
    for (int i = 0; i < N; i++)
      blk[MS-1-8*i -: 8] = 8'(i);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    iRst = 1'b1;
    bus.iStart = 1'b0;
    bus.iKey = '0;
    bus.iCipher_byte = 8'h00;
    bus.iCipher_valid = 1'b0;
    bus.iPlain_ready = 1'b0;
    ekey = '0;
    blk = '0;
    msg = '0;
    #2;
    check_reset("rst");
    tick();
    tick();
    iRst = 1'b0;

    // Directed decode, full rate
    count_blk();
    start(32'hDEADBEEF);
    feed(0, N - 1, 0);
    check("turn_ready", bus.oCipher_ready, 0);
    check("turn_valid", bus.oPlain_valid, 1);
    check("first_byte", bus.oPlain_byte, 8'hDE);
    drain(N, 0);
    check_done();

    // Round trip from DONE with random message
    for (int w = 0; w < MS / 32; w++)
      msg[w*32 +: 32] = $urandom;
    start($urandom);
    blk = msg ^ {(MS / KS){ekey}};
    for (int i = 0; i < N; i++) begin
      q.push_back(msg[MS-1-8*i -: 8]);
      send(blk[MS-1-8*i -: 8]);
    end
    drain(N, 0);
    check_done();

    // Valid gaps and ready stalls
    count_blk();
    start(32'hDEADBEEF);
    feed(0, N - 1, 40);
    drain(N, 40);
    check_done();

    // Reset mid-block
    start(32'hDEADBEEF);
    feed(0, 19, 0);
    iRst = 1'b1;
    #1;
    check_reset("mid_rst");
    q.delete();
    tick();
    iRst = 1'b0;
    bus.iCipher_valid = 1'b1;
    tick();
    tick();
    tick();
    bus.iCipher_valid = 1'b0;
    check_reset("no_start");
    start(32'hDEADBEEF);
    feed(0, N - 1, 0);
    drain(N, 0);
    check_done();

    // Ignored iStart in LOAD and DRAIN
    start(32'h0BADF00D);
    feed(0, 9, 0);
    bus.iKey = 32'hFFFFFFFF;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    check("load_ign_ready", bus.oCipher_ready, 1);
    feed(10, N - 1, 0);
    drain(5, 0);
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    check("drain_ign_valid", bus.oPlain_valid, 1);
    check("drain_ign_byte", bus.oPlain_byte, q[0]);
    drain(N - 5, 0);
    check_done();

`ifdef XOR_DECRYPT_CKSUM_EN
    blk = '0;
    blk[MS-1 -: 8] = 8'h01;
    start(32'h0);
    feed(0, N - 1, 0);
    drain(N, 0);
    check_done();
    check("cksum_one", cksum, 8'h01);
    blk = '0;
    start(32'h0);
    feed(0, N - 1, 0);
    drain(N, 0);
    check_done();
    check("cksum_zero", cksum, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xor_decrypt_stream.md
# xor_decrypt_stream

Byte-serial XOR decryptor forming the receive end of the XOR cipher path. Accepts a MSG_SIZE-bit ciphertext one byte at a time and XORs each byte with the repeating KEY_SIZE-bit key. It buffers the full plaintext block, then streams plaintext bytes out under a valid/ready handshake. It sits between the ciphertext byte source (UART/SPI-side deserializer) and the plaintext consumer, and inverts the block-parallel encryptor exactly.

## Interface
- KEY_SIZE, 32: key width in bits; multiple of 8; must divide MSG_SIZE.
- MSG_SIZE, 512: block width in bits; multiple of 8.
- iClk  input  1  clock; all state updates on the rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iStart  input  1  one-cycle pulse that begins a block; honoured only in IDLE or DONE.
- iKey  input  KEY_SIZE  key; sampled on an accepted iStart.
- iCipher_byte  input  8  ciphertext byte.
- iCipher_valid  input  1  iCipher_byte is valid.
- oCipher_ready  output  1  block can accept a ciphertext byte.
- oPlain_byte  output  8  plaintext byte.
- oPlain_valid  output  1  oPlain_byte is valid.
- iPlain_ready  input  1  consumer accepts oPlain_byte.
- oBusy  output  1  state is LOAD or DRAIN.
- oDecrypt_done  output  1  whole block drained; stays high until the next accepted iStart.

## Operation
- Block byte count is N = MSG_SIZE/8. Key byte count is K = KEY_SIZE/8.
- Byte ordering is MSB first.
  - Ciphertext byte i corresponds to bits [MSG_SIZE-1-8i -: 8] of the encryptor's block.
  - Key byte j is iKey[KEY_SIZE-1-8j -: 8].
- Plaintext byte i = cipher byte i XOR key byte (i mod K). The XOR is applied on input acceptance and the result is stored in the N-byte buffer.
- FSM states:
  - IDLE: iStart latches iKey, clears the counters and goes to LOAD.
  - LOAD: oCipher_ready=1. Each iCipher_valid&&oCipher_ready edge stores one byte and increments the input count and the key index (key index wraps K-1 to 0). Acceptance of byte N-1 moves to DRAIN.
  - DRAIN: oPlain_valid=1 and oPlain_byte = buffer byte at the output index. Each oPlain_valid&&iPlain_ready edge advances the index. The handshake on byte N-1 moves to DONE.
  - DONE: oDecrypt_done=1. iStart behaves as in IDLE, and the move to LOAD clears oDecrypt_done.
- iStart in LOAD or DRAIN is ignored.
- iCipher_valid outside LOAD is ignored and no byte is consumed.
- iPlain_ready outside DRAIN is ignored.
- Counters are $clog2(N)+1 bits wide, so the terminal count N is representable.
- Reset values: state IDLE. oCipher_ready=0, oPlain_valid=0, oPlain_byte=0, oBusy=0, oDecrypt_done=0. Buffer, counters and latched key are 0.
- Reset asserted mid-block aborts the block. No partial output is held. After release, the block waits in IDLE for iStart.

## Timing
- All outputs are registered, or decoded only from registered state.
- iStart accepted at edge t: oCipher_ready=1 from t+1.
- Input throughput is 1 byte/cycle while iCipher_valid stays high, so LOAD takes a minimum of N cycles.
- Last ciphertext byte accepted at edge t: oCipher_ready=0 and oPlain_valid=1 with byte 0 from t+1 (1-cycle turnaround).
- Output throughput is 1 byte/cycle while iPlain_ready stays high, so DRAIN takes a minimum of N cycles.
- When iPlain_ready=0, oPlain_byte and oPlain_valid hold stable.
- Last plaintext handshake at edge t: oPlain_valid=0 and oDecrypt_done=1 from t+1.
- Minimum iStart-to-done is 2N+1 cycles.
- iStart in DONE at edge t: oDecrypt_done=0 and oCipher_ready=1 from t+1.

## Configuration
- XOR_DECRYPT_CKSUM_EN defined: adds output oChecksum [7:0].
  - It is the running XOR of all plaintext bytes stored in the current block.
  - It clears on an accepted iStart and on reset, and is final and stable when oDecrypt_done=1.
- XOR_DECRYPT_CKSUM_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Decode: KEY_SIZE=32, MSG_SIZE=512, iKey=0xDEADBEEF, cipher byte i=i for i=0..63 -> plaintext stream starts 0xDE,0xAC,0xBC,0xEC,0xDA, and byte 63 is 0x3F^0xEF=0xD0. oDecrypt_done=1 exactly 1 cycle after the 64th output handshake.
- Round trip: random 512-bit message and 32-bit key encrypted by the block-parallel encryptor (key replicated across the block), fed MSB byte first -> output bytes equal the original message, MSB first.
- Backpressure and gaps:
  - Random iCipher_valid gaps and random iPlain_ready stalls give the same output as the first test.
  - oPlain_byte stays constant during every stall.
  - No byte is dropped or duplicated.
- Reset mid-block: assert iRst after 20 bytes accepted -> all outputs reach reset values immediately. iCipher_valid without iStart is ignored, and a fresh iStart and block decode correctly.
- Ignored controls:
  - iStart pulsed during LOAD and DRAIN does not change the state or the byte counts.
  - In DONE, iStart restarts and clears oDecrypt_done the next cycle.
- With XOR_DECRYPT_CKSUM_EN, iKey=0, cipher byte 0=0x01 and bytes 1..63=0x00 -> oChecksum=0x01 at done. The next block of all 0x00 gives oChecksum=0x00.
